// File: rtl/prim_intr_rx.sv
// Interrupt receiver: per-source edge/level gateways, priority/threshold arbitration
// and a PLIC-style claim/complete handshake for one hart context.
module prim_intr_rx #(
    parameter int unsigned Width = 8,
    parameter int unsigned PrioW = 2,
    parameter int unsigned IdW   = $clog2(Width + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [Width-1:0]       intr_src_i,
    input  logic [Width-1:0]       intr_level_i,
    input  logic [Width*PrioW-1:0] intr_prio_i,
    input  logic [PrioW-1:0]       threshold_i,
    output logic                   irq_o,
    output logic [IdW-1:0]         irq_id_o,
    input  logic                   claim_i,
    output logic [IdW-1:0]         claim_id_o,
    input  logic                   complete_i,
    input  logic [IdW-1:0]         complete_id_i
);

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    gw_state_e st_q [Width];
    gw_state_e st_d [Width];

    logic [Width-1:0] src_q;
    logic [Width-1:0] again_q, again_d;
    logic             irq_q, irq_d;
    logic [IdW-1:0]   irq_id_q, irq_id_d;
    logic [IdW-1:0]   claim_id_q, claim_id_d;

    logic [Width-1:0] src_edge_c;
    logic [Width-1:0] claim_hit_c;
    logic [Width-1:0] cmpl_hit_c;
    logic [PrioW-1:0] best_prio_c;
    logic [IdW-1:0]   best_id_c;
    logic             best_vld_c;

    assign src_edge_c = intr_src_i & ~src_q;

    // Claim/complete decode per gateway; IDs 0 and > Width never match.
    always_comb begin
        claim_hit_c = '0;
        cmpl_hit_c  = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            claim_hit_c[i] = claim_i & irq_q & (irq_id_q == IdW'(i + 1));
            cmpl_hit_c[i]  = complete_i & (complete_id_i == IdW'(i + 1));
        end
    end

    // Gateway next-state logic.
    always_comb begin
        st_d    = st_q;
        again_d = again_q;
        for (int unsigned i = 0; i < Width; i++) begin
            case (st_q[i])
                GW_IDLE: begin
                    if (intr_level_i[i] ? intr_src_i[i] : src_edge_c[i]) begin
                        st_d[i] = GW_PENDING;
                    end
                end
                GW_PENDING: begin
                    if (claim_hit_c[i]) begin
                        st_d[i] = GW_CLAIMED;
                    end
                end
                GW_CLAIMED: begin
                    // An edge coinciding with the complete is folded in so it is not lost.
                    if (cmpl_hit_c[i]) begin
                        again_d[i] = 1'b0;
                        if (again_q[i] | (src_edge_c[i] & ~intr_level_i[i])) begin
                            st_d[i] = GW_PENDING;
                        end else begin
                            st_d[i] = GW_IDLE;
                        end
                    end else if (src_edge_c[i] & ~intr_level_i[i]) begin
                        again_d[i] = 1'b1;
                    end
                end
                default: begin
                    st_d[i]    = GW_IDLE;
                    again_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Highest priority above threshold wins; ascending scan with strict compare keeps lowest ID on ties.
    always_comb begin
        best_prio_c = threshold_i;
        best_id_c   = '0;
        best_vld_c  = 1'b0;
        for (int unsigned i = 0; i < Width; i++) begin
            if ((st_q[i] == GW_PENDING) && (intr_prio_i[i*PrioW +: PrioW] > best_prio_c)) begin
                best_prio_c = intr_prio_i[i*PrioW +: PrioW];
                best_id_c   = IdW'(i + 1);
                best_vld_c  = 1'b1;
            end
        end
    end

    // A claim blanks the presented interrupt for one update.
    always_comb begin
        irq_d      = best_vld_c;
        irq_id_d   = best_id_c;
        claim_id_d = claim_id_q;
        if (claim_i) begin
            irq_d      = 1'b0;
            irq_id_d   = '0;
            claim_id_d = irq_q ? irq_id_q : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Width; i++) begin
                st_q[i] <= GW_IDLE;
            end
            src_q      <= '0;
            again_q    <= '0;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
            claim_id_q <= '0;
        end else begin
            for (int unsigned i = 0; i < Width; i++) begin
                st_q[i] <= st_d[i];
            end
            src_q      <= intr_src_i;
            again_q    <= again_d;
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
            claim_id_q <= claim_id_d;
        end
    end

    assign irq_o      = irq_q;
    assign irq_id_o   = irq_id_q;
    assign claim_id_o = claim_id_q;

endmodule

// File: tb/tb_prim_intr_rx.sv
// Directed bench for prim_intr_rx: claim results are scoreboarded through a queue,
// presented interrupts are checked against bench-computed expectations.
module tb_prim_intr_rx;

    localparam int unsigned Width = 8;
    localparam int unsigned PrioW = 2;
    localparam int unsigned IdW   = 4;

    logic                   clk;
    logic                   rst;
    logic [Width-1:0]       src;
    logic [Width-1:0]       level;
    logic [Width*PrioW-1:0] prio;
    logic [PrioW-1:0]       thr;
    logic                   irq;
    logic [IdW-1:0]         irq_id;
    logic                   claim;
    logic [IdW-1:0]         claim_id;
    logic                   cmpl;
    logic [IdW-1:0]         cmpl_id;

    int errors = 0;
    int checks = 0;
    int claim_q[$];

    prim_intr_rx #(.Width(Width), .PrioW(PrioW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .intr_src_i    (src),
        .intr_level_i  (level),
        .intr_prio_i   (prio),
        .threshold_i   (thr),
        .irq_o         (irq),
        .irq_id_o      (irq_id),
        .claim_i       (claim),
        .claim_id_o    (claim_id),
        .complete_i    (cmpl),
        .complete_id_i (cmpl_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int id, input logic [PrioW-1:0] p);
        prio[(id-1)*PrioW +: PrioW] = p;
    endtask

    task automatic pulse(input logic [Width-1:0] mask);
        src = src | mask;
        tick();
        src = src & ~mask;
    endtask

    task automatic do_claim(input int exp_id);
        int e;
        claim_q.push_back(exp_id);
        claim = 1'b1;
        tick();
        claim = 1'b0;
        e = claim_q.pop_front();
        check("claim_id", 32'(claim_id), 32'(e));
        check("irq_blank_after_claim", 32'(irq), 32'd0);
    endtask

    task automatic do_complete(input int id);
        cmpl    = 1'b1;
        cmpl_id = IdW'(id);
        tick();
        cmpl    = 1'b0;
        cmpl_id = '0;
    endtask

    task automatic wait_irq(input string tag, input int exp_id, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (irq === 1'b1) break;
            tick();
        end
        check({tag, "_irq"}, 32'(irq), 32'd1);
        check({tag, "_id"}, 32'(irq_id), 32'(exp_id));
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_id"}, 32'(irq_id), 32'd0);
    endtask

    initial begin
        rst = 1'b1; src = '0; level = '0; prio = '0; thr = '0;
        claim = 1'b0; cmpl = 1'b0; cmpl_id = '0;
        #1;
        expect_quiet("reset");
        check("reset_claim_id", 32'(claim_id), 32'd0);
        tick(2);
        rst = 1'b0;
        tick();

        // Edge basic: pending at edge k, presented at k+1.
        set_prio(4, 2'd2);
        pulse(8'h08);
        check("edge_lat_k", 32'(irq), 32'd0);
        tick();
        check("edge_lat_k1_irq", 32'(irq), 32'd1);
        check("edge_lat_k1_id", 32'(irq_id), 32'd4);
        do_claim(4);
        tick();
        expect_quiet("edge_claimed");
        do_complete(4);
        tick(3);
        expect_quiet("edge_idle");

        // Priority and tie-break.
        prio = '0;
        set_prio(2, 2'd1); set_prio(5, 2'd3); set_prio(7, 2'd3);
        pulse(8'h52);
        wait_irq("tie_a", 5, 4);
        do_claim(5); do_complete(5);
        wait_irq("tie_b", 7, 4);
        do_claim(7); do_complete(7);
        wait_irq("tie_c", 2, 4);
        do_claim(2); do_complete(2);
        tick();
        do_claim(0);

        // Threshold hides priority-1 source until lowered.
        thr = 2'd1;
        pulse(8'h52);
        wait_irq("thr_a", 5, 4);
        do_claim(5); do_complete(5);
        wait_irq("thr_b", 7, 4);
        do_claim(7); do_complete(7);
        tick(2);
        expect_quiet("thr_masked");
        do_claim(0);
        thr = 2'd0;
        wait_irq("thr_lowered", 2, 4);
        do_claim(2); do_complete(2);
        tick(2);

        // Level re-pend.
        prio = '0;
        set_prio(1, 2'd1);
        level[0] = 1'b1;
        src[0] = 1'b1;
        wait_irq("lvl_a", 1, 4);
        do_claim(1);
        do_complete(1);
        check("lvl_repend_c", 32'(irq), 32'd0);
        tick();
        check("lvl_repend_c1", 32'(irq), 32'd0);
        tick();
        check("lvl_repend_c2_irq", 32'(irq), 32'd1);
        check("lvl_repend_c2_id", 32'(irq_id), 32'd1);
        src[0] = 1'b0;
        tick();
        check("lvl_dropped_still_pending", 32'(irq_id), 32'd1);
        do_claim(1);
        do_complete(1);
        tick(3);
        expect_quiet("lvl_idle");
        level[0] = 1'b0;

        // Edges during CLAIMED collapse into a single re-presentation.
        prio = '0;
        set_prio(3, 2'd2);
        pulse(8'h04);
        wait_irq("again_a", 3, 4);
        do_claim(3);
        pulse(8'h04);
        tick();
        pulse(8'h04);
        tick();
        expect_quiet("again_claimed");
        do_complete(3);
        wait_irq("again_repend", 3, 4);
        do_claim(3);
        do_complete(3);
        tick(3);
        expect_quiet("again_idle");
        do_claim(0);

        // Illegal completes leave a pending ID 6 presented; back-to-back claims.
        prio = '0;
        set_prio(6, 2'd1);
        pulse(8'h20);
        wait_irq("illegal_setup", 6, 4);
        do_complete(0);
        check("cmpl0_irq", 32'(irq), 32'd1);
        check("cmpl0_id", 32'(irq_id), 32'd6);
        do_complete(9);
        check("cmpl9_id", 32'(irq_id), 32'd6);
        do_complete(6);
        check("cmpl6_unclaimed_irq", 32'(irq), 32'd1);
        check("cmpl6_unclaimed_id", 32'(irq_id), 32'd6);
        do_claim(6);
        do_claim(0);
        do_complete(6);
        tick(2);
        expect_quiet("b2b_idle");

        // Asynchronous reset mid-operation.
        prio = '0;
        set_prio(2, 2'd1); set_prio(4, 2'd2);
        pulse(8'h0a);
        wait_irq("rst_setup", 4, 4);
        do_claim(4);
        tick();
        check("rst_pre_id", 32'(irq_id), 32'd2);
        #2 rst = 1'b1;
        #1;
        expect_quiet("rst_async");
        check("rst_async_claim_id", 32'(claim_id), 32'd0);
        tick();
        rst = 1'b0;
        tick(4);
        expect_quiet("rst_released");
        pulse(8'h02);
        wait_irq("rst_new_edge", 2, 4);

        // Source high across reset release counts as an edge.
        prio = '0;
        set_prio(7, 2'd1);
        src[6] = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        wait_irq("held_high", 7, 4);
        src = '0;

        check("scoreboard_drained", 32'(claim_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
